// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/handshake bundle between the multicycle controller and its datapath/memories
interface multicycle_ctrl_if;
    // Inputs to the controller
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        br_taken;

    // Controller outputs
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        word32;
    logic        retire;
    logic        illegal;
    logic        bus_err;

    // Controller side
    modport master (
        input  instr, imem_ready, dmem_ready, br_taken,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, rf_we, wb_sel,
               alu_src_a, alu_src_b, alu_op, word32, retire, illegal, bus_err
    );

    // Datapath / memory side
    modport slave (
        output instr, imem_ready, dmem_ready, br_taken,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, rf_we, wb_sel,
               alu_src_a, alu_src_b, alu_op, word32, retire, illegal, bus_err
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV64I core
module multicycle_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_ERROR
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_RW, C_I, C_IW, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } cls_t;

    // The counter only has to reach TIMEOUT-1 before the trip decision is made.
    localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam bit            WD_EN   = (TIMEOUT != 0);

    state_t        state_q, state_d;
    cls_t          cls_q, cls_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic stalled;
    logic wd_expire;

    // Only the opcode field steers control; the rest of IR belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[31:7];

    function automatic cls_t classify(input logic [6:0] opc);
        case (opc)
            7'b0110011: return C_R;
            7'b0111011: return C_RW;
            7'b0010011: return C_I;
            7'b0011011: return C_IW;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    // Next-state, latched instruction class and memory-stall watchdog.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wd_cnt_d  = wd_cnt_q;
        stalled   = ((state_q == S_FETCH) && !bus.imem_ready) ||
                    ((state_q == S_MEM)   && !bus.dmem_ready);
        // A ready in the final allowed cycle wins because stalled is then low.
        wd_expire = WD_EN && stalled && (wd_cnt_q == WD_LAST);

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready)  state_d = S_DECODE;
                else if (wd_expire)  state_d = S_ERROR;
            end
            S_DECODE: begin
                cls_d   = classify(bus.instr[6:0]);
                state_d = (classify(bus.instr[6:0]) == C_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE:         state_d = S_MEM;
                    C_BRANCH, C_JAL, C_JALR: state_d = S_FETCH;
                    default:                 state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready)  state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                else if (wd_expire)  state_d = S_ERROR;
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            wd_cnt_d = '0;
        else if (WD_EN && stalled)
            wd_cnt_d = wd_cnt_q + CW'(1);
    end

    // State registers; reset parks the controller in IDLE with everything quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cls_q    <= C_ILL;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Control outputs decoded from state and latched class, qualified by ready/br_taken.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'd0;
        bus.rf_we     = 1'b0;
        bus.wb_sel    = 2'd0;
        bus.alu_src_a = 2'd0;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 2'd0;
        bus.word32    = 1'b0;
        bus.retire    = 1'b0;
        bus.illegal   = 1'b0;
        bus.bus_err   = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ready;
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        bus.alu_op = 2'd2;
                    end
                    C_RW: begin
                        bus.alu_op = 2'd2;
                        bus.word32 = 1'b1;
                    end
                    C_I: begin
                        bus.alu_src_b = 1'b1;
                        bus.alu_op    = 2'd2;
                    end
                    C_IW: begin
                        bus.alu_src_b = 1'b1;
                        bus.alu_op    = 2'd2;
                        bus.word32    = 1'b1;
                    end
                    C_LUI: begin
                        bus.alu_src_a = 2'd2;
                        bus.alu_src_b = 1'b1;
                    end
                    C_AUIPC: begin
                        bus.alu_src_a = 2'd1;
                        bus.alu_src_b = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        bus.alu_src_b = 1'b1;
                    end
                    C_BRANCH: begin
                        bus.alu_op = 2'd1;
                        bus.pc_we  = 1'b1;
                        bus.pc_src = bus.br_taken ? 2'd1 : 2'd0;
                        bus.retire = 1'b1;
                    end
                    C_JAL: begin
                        bus.rf_we  = 1'b1;
                        bus.wb_sel = 2'd2;
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'd1;
                        bus.retire = 1'b1;
                    end
                    C_JALR: begin
                        bus.alu_src_b = 1'b1;
                        bus.rf_we     = 1'b1;
                        bus.wb_sel    = 2'd2;
                        bus.pc_we     = 1'b1;
                        bus.pc_src    = 2'd2;
                        bus.retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Address operands stay selected for the whole access.
                bus.dmem_req  = 1'b1;
                bus.dmem_we   = (cls_q == C_STORE);
                bus.alu_src_b = 1'b1;
                if ((cls_q == C_STORE) && bus.dmem_ready) begin
                    bus.pc_we  = 1'b1;
                    bus.retire = 1'b1;
                end
            end
            S_WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = (cls_q == C_LOAD) ? 2'd1 : 2'd0;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
            end
            S_TRAP:  bus.illegal = 1'b1;
            S_ERROR: bus.bus_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       word32;
        logic       retire;
        logic       illegal;
        logic       bus_err;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        ri;
        logic        rd;
        logic        br;
        out_t        exp;
    } step_t;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LD    = 32'h0000B103;
    localparam logic [31:0] I_SD    = 32'h0020B023;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    step_t sb_q[$];

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    out_t obs;
    assign obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_src,
                  bus.rf_we, bus.wb_sel, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.word32, bus.retire, bus.illegal, bus.bus_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    // Expected-output constructors
    function automatic out_t e_fetch(input logic irw);
        out_t t = '0;
        t.imem_req = 1'b1;
        t.ir_we    = irw;
        return t;
    endfunction

    function automatic out_t e_alu(input logic [1:0] sa, input logic sb, input logic [1:0] op, input logic w32);
        out_t t = '0;
        t.alu_src_a = sa;
        t.alu_src_b = sb;
        t.alu_op    = op;
        t.word32    = w32;
        return t;
    endfunction

    function automatic out_t e_mem(input logic we, input logic done);
        out_t t = '0;
        t.dmem_req  = 1'b1;
        t.dmem_we   = we;
        t.alu_src_b = 1'b1;
        t.pc_we     = done;
        t.retire    = done;
        return t;
    endfunction

    function automatic out_t e_wb(input logic [1:0] wbs);
        out_t t = '0;
        t.rf_we  = 1'b1;
        t.wb_sel = wbs;
        t.pc_we  = 1'b1;
        t.retire = 1'b1;
        return t;
    endfunction

    function automatic out_t e_ctl(input logic rfw, input logic [1:0] wbs, input logic [1:0] pcs,
                                   input logic sb, input logic [1:0] op);
        out_t t = '0;
        t.rf_we     = rfw;
        t.wb_sel    = wbs;
        t.pc_src    = pcs;
        t.alu_src_b = sb;
        t.alu_op    = op;
        t.pc_we     = 1'b1;
        t.retire    = 1'b1;
        return t;
    endfunction

    function automatic out_t e_flag(input logic ill, input logic berr);
        out_t t = '0;
        t.illegal = ill;
        t.bus_err = berr;
        return t;
    endfunction

    task automatic push(input logic [31:0] ins, input logic ri, input logic rd, input logic br, input out_t e);
        step_t s;
        s.instr = ins;
        s.ri    = ri;
        s.rd    = rd;
        s.br    = br;
        s.exp   = e;
        sb_q.push_back(s);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.dmem_ready  = 1'b0;
        bus.br_taken    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step_t s;
        int n = 0;
        bus.instr      = I_ADDI;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        bus.br_taken   = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== out_t'('0)) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obs, out_t'('0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(I_ADDI, 1'b1, 1'b1, 1'b1, '0);
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL reset_release step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_addi();
        step_t s;
        int n = 0;
        do_reset();
        push(I_ADDI, 1'b0, 1'b0, 1'b0, '0);
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        push(I_ADDI, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_ADDI, 1'b0, 1'b0, 1'b0, '0);
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_alu(2'd0, 1'b1, 2'd2, 1'b0));
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_wb(2'd0));
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL addi step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu_classes();
        logic [31:0] ins  [5];
        out_t        exec [5];
        step_t s;
        ins[0] = 32'h002081B3; exec[0] = e_alu(2'd0, 1'b0, 2'd2, 1'b0);
        ins[1] = 32'h002080BB; exec[1] = e_alu(2'd0, 1'b0, 2'd2, 1'b1);
        ins[2] = 32'h0050809B; exec[2] = e_alu(2'd0, 1'b1, 2'd2, 1'b1);
        ins[3] = 32'h000010B7; exec[3] = e_alu(2'd2, 1'b1, 2'd0, 1'b0);
        ins[4] = 32'h00001097; exec[4] = e_alu(2'd1, 1'b1, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            do_reset();
            push(ins[k], 1'b0, 1'b0, 1'b0, '0);
            push(ins[k], 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
            push(ins[k], 1'b0, 1'b0, 1'b0, '0);
            push(ins[k], 1'b0, 1'b0, 1'b0, exec[k]);
            push(ins[k], 1'b0, 1'b0, 1'b0, e_wb(2'd0));
            while (sb_q.size() > 0) begin
                s = sb_q.pop_front();
                bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
                @(negedge clk);
                checks++;
                if (obs !== s.exp) begin
                    errors++;
                    $display("FAIL alu_class instr %h step %0d: got %h expected %h", ins[k], n, obs, s.exp);
                end
                n++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_load();
        step_t s;
        int n = 0;
        do_reset();
        push(I_LD, 1'b0, 1'b0, 1'b0, '0);
        push(I_LD, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_LD, 1'b0, 1'b0, 1'b0, '0);
        push(I_LD, 1'b0, 1'b0, 1'b0, e_alu(2'd0, 1'b1, 2'd0, 1'b0));
        for (int k = 0; k < 3; k++)
            push(I_LD, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        push(I_LD, 1'b0, 1'b1, 1'b0, e_mem(1'b0, 1'b0));
        push(I_LD, 1'b0, 1'b0, 1'b0, e_wb(2'd1));
        push(I_LD, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL load step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store();
        step_t s;
        int n = 0;
        do_reset();
        push(I_SD, 1'b0, 1'b0, 1'b0, '0);
        push(I_SD, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_SD, 1'b0, 1'b0, 1'b0, '0);
        push(I_SD, 1'b0, 1'b0, 1'b0, e_alu(2'd0, 1'b1, 2'd0, 1'b0));
        push(I_SD, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0));
        push(I_SD, 1'b0, 1'b1, 1'b0, e_mem(1'b1, 1'b1));
        push(I_SD, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL store step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        int n = 0;
        do_reset();
        push(I_BEQ,  1'b0, 1'b0, 1'b0, '0);
        push(I_BEQ,  1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_BEQ,  1'b0, 1'b0, 1'b1, '0);
        push(I_BEQ,  1'b0, 1'b0, 1'b1, e_ctl(1'b0, 2'd0, 2'd1, 1'b0, 2'd1));
        push(I_BEQ,  1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_BEQ,  1'b0, 1'b0, 1'b0, '0);
        push(I_BEQ,  1'b0, 1'b0, 1'b0, e_ctl(1'b0, 2'd0, 2'd0, 1'b0, 2'd1));
        push(I_JALR, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_JALR, 1'b0, 1'b0, 1'b0, '0);
        push(I_JALR, 1'b0, 1'b0, 1'b0, e_ctl(1'b1, 2'd2, 2'd2, 1'b1, 2'd0));
        push(I_JAL,  1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_JAL,  1'b0, 1'b0, 1'b0, '0);
        push(I_JAL,  1'b0, 1'b0, 1'b0, e_ctl(1'b1, 2'd2, 2'd1, 1'b0, 2'd0));
        push(I_JAL,  1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_trap();
        step_t s;
        int n = 0;
        do_reset();
        push(I_BAD, 1'b0, 1'b0, 1'b0, '0);
        push(I_BAD, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_BAD, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++)
            push(I_BAD, 1'b1, 1'b1, 1'b1, e_flag(1'b1, 1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL trap step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
        do_reset();
        push(I_ADDI, 1'b0, 1'b0, 1'b0, '0);
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        n = 0;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL trap_cleared step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_watchdog();
        step_t s;
        int n = 0;
        do_reset();
        push(I_ADDI, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++)
            push(I_ADDI, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        push(I_ADDI, 1'b1, 1'b1, 1'b0, e_flag(1'b0, 1'b1));
        push(I_ADDI, 1'b1, 1'b1, 1'b0, e_flag(1'b0, 1'b1));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL watchdog_trip step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
        do_reset();
        push(I_ADDI, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++)
            push(I_ADDI, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        push(I_ADDI, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_ADDI, 1'b0, 1'b0, 1'b0, '0);
        push(I_ADDI, 1'b0, 1'b0, 1'b0, e_alu(2'd0, 1'b1, 2'd2, 1'b0));
        n = 0;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL watchdog_ready_wins step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t s;
        int n = 0;
        do_reset();
        push(I_LD, 1'b0, 1'b0, 1'b0, '0);
        push(I_LD, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
        push(I_LD, 1'b0, 1'b0, 1'b0, '0);
        push(I_LD, 1'b0, 1'b0, 1'b0, e_alu(2'd0, 1'b1, 2'd0, 1'b0));
        push(I_LD, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL mid_mem step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
        #2;
        checks++;
        if (obs !== e_mem(1'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_mem_before_reset: got %h expected %h", obs, e_mem(1'b0, 1'b0));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== out_t'('0)) begin
            errors++;
            $display("FAIL mid_mem_reset_immediate: got %h expected %h", obs, out_t'('0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(I_LD, 1'b0, 1'b1, 1'b0, '0);
        push(I_LD, 1'b0, 1'b1, 1'b0, e_fetch(1'b0));
        n = 0;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            bus.instr = s.instr; bus.imem_ready = s.ri; bus.dmem_ready = s.rd; bus.br_taken = s.br;
            @(negedge clk);
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL mid_mem_restart step %0d: got %h expected %h", n, obs, s.exp);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.instr      = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.br_taken   = 1'b0;
        test_reset();
        test_addi();
        test_alu_classes();
        test_load();
        test_store();
        test_back_to_back();
        test_trap();
        test_watchdog();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
